tc_sram_sp_hs: RTL and testbench

- Parametrised single-port SRAM with byte-write mask and valid/ready request and response channels.
- Successor to the fixed 1024x32 macro wrapper: width and depth are generic.
- Adds a post-reset zero-initialisation sequencer, read-response backpressure with data hold, and out-of-range detection.
- Sits between SoC bus adapters (core-local RAM, DMA buffers) and the storage array; the array is behavioural here.

---
 rtl/tc_sram_sp_hs_if.sv | 32 +++
 rtl/tc_sram_sp_hs.sv | 134 +++++++++++++
 tb/tb_tc_sram_sp_hs.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tc_sram_sp_hs_if.sv
// Request/response bus for tc_sram_sp_hs: valid/ready request channel with byte mask,
// valid/ready read-response channel, and the init-done status flag.
`timescale 1ns/1ps
interface tc_sram_sp_hs_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                    req_valid_i;
  logic                    req_ready_o;
  logic                    req_wren_i;
  logic [ADDR_WIDTH-1:0]   req_addr_i;
  logic [DATA_WIDTH-1:0]   req_data_i;
  logic [DATA_WIDTH/8-1:0] req_mask_i;
  logic                    parity_inj_i;
  logic                    rsp_valid_o;
  logic                    rsp_ready_i;
  logic [DATA_WIDTH-1:0]   rsp_data_o;
  logic                    rsp_err_o;
  logic                    init_done_o;

  modport slave (
    input  req_valid_i, req_wren_i, req_addr_i, req_data_i, req_mask_i,
           parity_inj_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, init_done_o
  );

  modport master (
    output req_valid_i, req_wren_i, req_addr_i, req_data_i, req_mask_i,
           parity_inj_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, init_done_o
  );
endinterface

// File: rtl/tc_sram_sp_hs.sv
// Parametrised single-port SRAM with byte mask, post-reset zero-init and held read responses.
// Optional per-byte even parity with write-side error injection: define TC_SRAM_PARITY_EN.
`timescale 1ns/1ps
module tc_sram_sp_hs #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 10,
  parameter int INIT_ZERO  = 1
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  tc_sram_sp_hs_if.slave bus
);
  // state | meaning
  // INIT  | clearing the array one word per cycle (or passing straight through if INIT_ZERO=0)
  // RUN   | array usable, requests accepted
  localparam int         NB     = DATA_WIDTH / 8;
  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_init_cnt;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic                  r_rsp_err;

  logic                  w_run;
  logic                  w_init_wr;
  logic                  w_in_range;
  logic                  w_req_ready;
  logic                  w_wr_fire;
  logic                  w_rd_fire;
  logic                  w_par_err;
  logic [DATA_WIDTH-1:0] w_rd_word;

  assign w_run       = (r_state == S_RUN);
  assign w_init_wr   = (r_state == S_INIT) && (INIT_ZERO != 0);
  assign w_in_range  = ({1'b0, bus.req_addr_i} < (ADDR_WIDTH+1)'(DEPTH));
  // A pending unconsumed response only blocks reads; writes never produce one.
  assign w_req_ready = w_run && (bus.req_wren_i || !r_rsp_valid || bus.rsp_ready_i);
  assign w_wr_fire   = bus.req_valid_i && w_req_ready && bus.req_wren_i;
  assign w_rd_fire   = bus.req_valid_i && w_req_ready && !bus.req_wren_i;
  assign w_rd_word   = w_in_range ? r_mem[bus.req_addr_i] : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state    <= S_INIT;
      r_init_cnt <= '0;
    end else begin
      case (r_state)
        S_INIT: begin
          if (INIT_ZERO == 0) begin
            r_state <= S_RUN;
          end else if (r_init_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
            r_state <= S_RUN;
          end else begin
            r_init_cnt <= r_init_cnt + 1'b1;
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  // Array has no reset so contents survive a reset when INIT_ZERO=0.
  always_ff @(posedge clk_i) begin
    if (rst_n_i) begin
      if (w_init_wr) begin
        r_mem[r_init_cnt] <= '0;
      end else if (w_wr_fire && w_in_range) begin
        for (int b = 0; b < NB; b++) begin
          if (bus.req_mask_i[b]) begin
            r_mem[bus.req_addr_i][8*b +: 8] <= bus.req_data_i[8*b +: 8];
          end
        end
      end
    end
  end

`ifdef TC_SRAM_PARITY_EN
  logic [NB-1:0] r_par [DEPTH];
  logic [NB-1:0] w_rd_par;

  assign w_rd_par = w_in_range ? r_par[bus.req_addr_i] : '0;

  always_ff @(posedge clk_i) begin
    if (rst_n_i) begin
      if (w_init_wr) begin
        r_par[r_init_cnt] <= '0;
      end else if (w_wr_fire && w_in_range) begin
        for (int b = 0; b < NB; b++) begin
          if (bus.req_mask_i[b]) begin
            r_par[bus.req_addr_i][b] <= (^bus.req_data_i[8*b +: 8]) ^ bus.parity_inj_i;
          end
        end
      end
    end
  end

  always_comb begin
    w_par_err = 1'b0;
    if (w_in_range) begin
      for (int b = 0; b < NB; b++) begin
        if ((^w_rd_word[8*b +: 8]) != w_rd_par[b]) begin
          w_par_err = 1'b1;
        end
      end
    end
  end
`else
  assign w_par_err = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else if (w_rd_fire) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= w_rd_word;
      r_rsp_err   <= !w_in_range || w_par_err;
    end else if (bus.rsp_ready_i) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign bus.req_ready_o = w_req_ready;
  assign bus.rsp_valid_o = r_rsp_valid;
  assign bus.rsp_data_o  = r_rsp_data;
  assign bus.rsp_err_o   = r_rsp_err;
  assign bus.init_done_o = w_run;
endmodule

// File: tb/tb_tc_sram_sp_hs.sv
// Self-checking bench for tc_sram_sp_hs (DEPTH=1000 so out-of-range addresses exist).
`timescale 1ns/1ps
module tb_tc_sram_sp_hs;
  localparam int DW    = 32;
  localparam int DEPTH = 1000;
  localparam int AW    = 10;
`ifdef TC_SRAM_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_n_i = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [DW-1:0] model_mem [DEPTH];
  logic [3:0]    model_bad [DEPTH];

  tc_sram_sp_hs_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  tc_sram_sp_hs #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .INIT_ZERO(1)) u_dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = '0;
      model_bad[i] = '0;
    end
  endfunction

  function automatic void model_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                      input logic [3:0] m, input logic inj);
    if (int'(a) < DEPTH) begin
      for (int b = 0; b < 4; b++) begin
        if (m[b]) begin
          model_mem[a][8*b +: 8] = d[8*b +: 8];
          model_bad[a][b]        = inj;
        end
      end
    end
  endfunction

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
    return (int'(a) < DEPTH) ? model_mem[a] : '0;
  endfunction

  function automatic logic exp_err(input logic [AW-1:0] a);
    if (int'(a) >= DEPTH) return 1'b1;
    return PAR_EN && (|model_bad[a]);
  endfunction

  // All helpers start and end at posedge+1.
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [3:0] m, input logic inj);
    bus.req_valid_i = 1'b1; bus.req_wren_i = 1'b1; bus.req_addr_i = a;
    bus.req_data_i = d; bus.req_mask_i = m; bus.parity_inj_i = inj; bus.rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    model_write(a, d, m, inj);
    bus.req_valid_i = 1'b0; bus.parity_inj_i = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, output logic v, output logic [DW-1:0] d,
                         output logic e);
    bus.req_valid_i = 1'b1; bus.req_wren_i = 1'b0; bus.req_addr_i = a; bus.rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    v = bus.rsp_valid_o; d = bus.rsp_data_o; e = bus.rsp_err_o;
    bus.req_valid_i = 1'b0;
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (n < 3 * DEPTH) begin
      @(posedge clk_i); #1;
      n++;
      if (bus.init_done_o) break;
    end
  endtask

  task automatic test_reset();
    int n;
    logic v, e;
    logic [DW-1:0] d;
    rst_n_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    n_checks++; if (bus.req_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready got=%b exp=0", bus.req_ready_o); end
    n_checks++; if (bus.rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid got=%b exp=0", bus.rsp_valid_o); end
    n_checks++; if (bus.rsp_data_o !== '0) begin n_fail++; $display("FAIL rst_rsp_data got=%h exp=0", bus.rsp_data_o); end
    n_checks++; if (bus.rsp_err_o !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_err got=%b exp=0", bus.rsp_err_o); end
    n_checks++; if (bus.init_done_o !== 1'b0) begin n_fail++; $display("FAIL rst_init_done got=%b exp=0", bus.init_done_o); end
    rst_n_i = 1'b1;
    wait_init(n);
    model_clear();
    n_checks++; if (n != DEPTH) begin n_fail++; $display("FAIL init_latency got=%0d exp=%0d", n, DEPTH); end
    do_read(AW'(DEPTH - 1), v, d, e);
    n_checks++; if (v !== 1'b1 || d !== 32'h0 || e !== 1'b0)
      begin n_fail++; $display("FAIL init_last_word got v=%b d=%h e=%b exp v=1 d=0 e=0", v, d, e); end
  endtask

  task automatic test_mask();
    logic v, e;
    logic [DW-1:0] d;
    do_write(10'h010, 32'hDEADBEEF, 4'hF, 1'b0);
    do_write(10'h010, 32'h11223344, 4'h5, 1'b0);
    do_read(10'h010, v, d, e);
    n_checks++; if (v !== 1'b1 || d !== 32'hDE22BE44 || e !== 1'b0)
      begin n_fail++; $display("FAIL mask_merge got v=%b d=%h e=%b exp d=DE22BE44", v, d, e); end
    do_write(10'h010, 32'hFFFFFFFF, 4'h0, 1'b0);
    do_read(10'h010, v, d, e);
    n_checks++; if (d !== exp_data(10'h010)) begin n_fail++; $display("FAIL mask_zero got=%h exp=%h", d, exp_data(10'h010)); end
  endtask

  task automatic test_oob();
    logic v, e;
    logic [DW-1:0] d;
    do_write(10'd999, 32'h5A5A0F0F, 4'hF, 1'b0);
    do_write(10'd1000, 32'hA5A5A5A5, 4'hF, 1'b0);
    do_read(10'd1000, v, d, e);
    n_checks++; if (v !== 1'b1 || d !== 32'h0 || e !== 1'b1)
      begin n_fail++; $display("FAIL oob_read got v=%b d=%h e=%b exp v=1 d=0 e=1", v, d, e); end
    do_read(10'd999, v, d, e);
    n_checks++; if (d !== 32'h5A5A0F0F || e !== 1'b0)
      begin n_fail++; $display("FAIL oob_neighbour got d=%h e=%b exp d=5A5A0F0F e=0", d, e); end
  endtask

  task automatic test_random();
    logic wr, inj;
    logic [AW-1:0] a;
    logic [DW-1:0] d, nd;
    logic [3:0] m;
    logic ne;
    for (int i = 0; i < 120; i++) begin
      wr  = 1'($urandom_range(0, 1));
      a   = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 1023)) : AW'($urandom_range(990, 1009));
      d   = $urandom;
      m   = 4'($urandom);
      inj = ($urandom_range(0, 3) == 0);
      bus.req_valid_i = 1'b1; bus.req_wren_i = wr; bus.req_addr_i = a; bus.req_data_i = d;
      bus.req_mask_i = m; bus.parity_inj_i = inj; bus.rsp_ready_i = 1'b1;
      nd = exp_data(a); ne = exp_err(a);
      #1;
      n_checks++; if (bus.req_ready_o !== 1'b1) begin n_fail++; $display("FAIL rand_ready i=%0d got=%b exp=1", i, bus.req_ready_o); end
      @(posedge clk_i); #1;
      if (wr) model_write(a, d, m, inj);
      n_checks++; if (bus.rsp_valid_o !== !wr) begin n_fail++; $display("FAIL rand_valid i=%0d got=%b exp=%b", i, bus.rsp_valid_o, !wr); end
      if (!wr) begin
        n_checks++; if (bus.rsp_data_o !== nd || bus.rsp_err_o !== ne)
          begin n_fail++; $display("FAIL rand_read i=%0d a=%0d got d=%h e=%b exp d=%h e=%b", i, a, bus.rsp_data_o, bus.rsp_err_o, nd, ne); end
      end
    end
    bus.req_valid_i = 1'b0; bus.parity_inj_i = 1'b0;
  endtask

  task automatic test_backpressure(input bit random_stall);
    logic [AW-1:0] addrs [8];
    int nreq, issued, got;
    logic pend, rr, acc;
    logic [DW-1:0] cur;
    logic cur_e;
    nreq = random_stall ? 8 : 4;
    for (int i = 0; i < nreq; i++) begin
      addrs[i] = AW'(100 + i);
      do_write(addrs[i], $urandom, 4'hF, 1'b0);
    end
    issued = 0; got = 0; pend = 1'b0; cur = '0; cur_e = 1'b0;
    for (int c = 0; c < 200 && got < nreq; c++) begin
      rr = random_stall ? ($urandom_range(0, 2) != 0) : ((c < 2) || (c >= 6));
      bus.req_valid_i = (issued < nreq); bus.req_wren_i = 1'b0;
      bus.req_addr_i = addrs[(issued < nreq) ? issued : 0]; bus.rsp_ready_i = rr;
      #1;
      n_checks++; if (bus.req_ready_o !== (!pend || rr))
        begin n_fail++; $display("FAIL bp_ready c=%0d got=%b exp=%b", c, bus.req_ready_o, !pend || rr); end
      n_checks++; if (bus.rsp_valid_o !== pend)
        begin n_fail++; $display("FAIL bp_valid c=%0d got=%b exp=%b", c, bus.rsp_valid_o, pend); end
      if (pend) begin
        n_checks++; if (bus.rsp_data_o !== cur || bus.rsp_err_o !== cur_e)
          begin n_fail++; $display("FAIL bp_data c=%0d got=%h/%b exp=%h/%b", c, bus.rsp_data_o, bus.rsp_err_o, cur, cur_e); end
      end
      acc = (issued < nreq) && (!pend || rr);
      @(posedge clk_i); #1;
      if (pend && rr) begin pend = 1'b0; got++; end
      if (acc) begin
        pend = 1'b1; cur = exp_data(addrs[issued]); cur_e = exp_err(addrs[issued]); issued++;
      end
    end
    bus.req_valid_i = 1'b0; bus.rsp_ready_i = 1'b1;
    n_checks++; if (got != nreq) begin n_fail++; $display("FAIL bp_count got=%0d exp=%0d", got, nreq); end
  endtask

  task automatic test_parity();
    logic v, e;
    logic [DW-1:0] d;
    do_write(10'd32, 32'h000000FF, 4'h1, 1'b1);
    do_read(10'd32, v, d, e);
    n_checks++; if (d !== 32'h000000FF || e !== (PAR_EN ? 1'b1 : 1'b0))
      begin n_fail++; $display("FAIL parity_inj got d=%h e=%b exp d=000000FF e=%b", d, e, PAR_EN); end
    do_write(10'd32, 32'h000000FF, 4'h1, 1'b0);
    do_read(10'd32, v, d, e);
    n_checks++; if (d !== 32'h000000FF || e !== 1'b0)
      begin n_fail++; $display("FAIL parity_clean got d=%h e=%b exp d=000000FF e=0", d, e); end
  endtask

  task automatic test_reset_mid_init();
    int n;
    logic v, e;
    logic [DW-1:0] d;
    do_write(10'd5, 32'h12345678, 4'hF, 1'b0);
    bus.req_valid_i = 1'b1; bus.req_wren_i = 1'b0; bus.req_addr_i = 10'd5; bus.rsp_ready_i = 1'b0;
    @(posedge clk_i); #1;
    bus.req_valid_i = 1'b0;
    n_checks++; if (bus.rsp_valid_o !== 1'b1 || bus.rsp_data_o !== 32'h12345678)
      begin n_fail++; $display("FAIL pend_before_rst got v=%b d=%h exp v=1 d=12345678", bus.rsp_valid_o, bus.rsp_data_o); end
    rst_n_i = 1'b0;
    @(posedge clk_i); #1;
    n_checks++; if (bus.rsp_valid_o !== 1'b0 || bus.rsp_data_o !== '0 || bus.init_done_o !== 1'b0 || bus.req_ready_o !== 1'b0)
      begin n_fail++; $display("FAIL rst_drop got v=%b d=%h done=%b rdy=%b exp all 0", bus.rsp_valid_o, bus.rsp_data_o, bus.init_done_o, bus.req_ready_o); end
    rst_n_i = 1'b1; bus.rsp_ready_i = 1'b1;
    repeat (500) @(posedge clk_i);
    #1;
    n_checks++; if (bus.init_done_o !== 1'b0) begin n_fail++; $display("FAIL mid_init_done got=%b exp=0", bus.init_done_o); end
    rst_n_i = 1'b0;
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    wait_init(n);
    model_clear();
    n_checks++; if (n != DEPTH) begin n_fail++; $display("FAIL reinit_latency got=%0d exp=%0d", n, DEPTH); end
    do_read(10'd5, v, d, e);
    n_checks++; if (v !== 1'b1 || d !== exp_data(10'd5) || e !== 1'b0)
      begin n_fail++; $display("FAIL reinit_cleared got v=%b d=%h e=%b exp v=1 d=0 e=0", v, d, e); end
  endtask

  initial begin
    bus.req_valid_i = 1'b0; bus.req_wren_i = 1'b0; bus.req_addr_i = '0; bus.req_data_i = '0;
    bus.req_mask_i = '0; bus.parity_inj_i = 1'b0; bus.rsp_ready_i = 1'b1;
    test_reset();
    test_mask();
    test_oob();
    test_backpressure(1'b0);
    test_backpressure(1'b1);
    test_random();
    test_parity();
    test_reset_mid_init();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
